// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter.
// Holds the FSM state encoding, default timing parameters and counter widths.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } arb_state_e;

    localparam int unsigned MemLatDefault    = 2;
    localparam int unsigned StarveMaxDefault = 4;

    // lat_cnt covers MEM_LAT-1 for MEM_LAT up to 15
    localparam int unsigned LatCntW    = 4;
    localparam int unsigned StarveCntW = 3;

endpackage

// File: rtl/mem_port_arbiter_access_timer.sv
// access_timer: per-access latency counter for the memory port arbiter.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-low reset
//   load     - load load_val (asserted on the grant cycle)
//   load_val - initial count, MEM_LAT-1
//   zero     - high when the count has reached zero (final access cycle)
module access_timer
    import mem_port_arbiter_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [LatCntW-1:0] load_val,
    output logic               zero
);

    logic [LatCntW-1:0] lat_cnt_q;
    logic [LatCntW-1:0] lat_cnt_d;

    always_comb begin
        lat_cnt_d = lat_cnt_q;
        if (load) begin
            lat_cnt_d = load_val;
        end else if (lat_cnt_q != '0) begin
            lat_cnt_d = lat_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_cnt_q <= '0;
        end else begin
            lat_cnt_q <= lat_cnt_d;
        end
    end

    assign zero = (lat_cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified memory between instruction fetch and
// data accesses. Data wins ties unless the fetch has been passed over
// STARVE_MAX consecutive times. One access is in flight at a time and an IDLE
// bubble separates consecutive accesses.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   if_req/if_addr                - fetch request and address (held until if_ack)
//   if_ack/if_rdata               - fetch completion pulse and instruction word
//   dm_req/dm_we/dm_addr/dm_wdata - data request (held until dm_ack)
//   dm_ack/dm_rdata               - data completion pulse and load data
//   mem_en/mem_we/mem_addr/mem_wdata, mem_rdata - unified memory port
//   stall_if, stall_mem           - pipeline stall requests
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = MemLatDefault,
    parameter int unsigned STARVE_MAX = StarveMaxDefault
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ack,
    output logic [31:0] dm_rdata,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        stall_if,
    output logic        stall_mem
);

    localparam logic [LatCntW-1:0]    LatLoad   = LatCntW'(MEM_LAT - 1);
    localparam logic [StarveCntW-1:0] StarveMax = StarveCntW'(STARVE_MAX);

    arb_state_e            state_q;
    arb_state_e            state_d;
    logic [StarveCntW-1:0] starve_q;
    logic [StarveCntW-1:0] starve_d;
    logic                  grant_i;
    logic                  grant_d;
    logic                  lat_zero;

    logic                  mem_en_q;
    logic                  mem_we_q;
    logic [31:0]           mem_addr_q;
    logic [31:0]           mem_wdata_q;

    // Grant decision, only meaningful in IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state_q == StIdle) begin
            if (dm_req && !(if_req && (starve_q == StarveMax))) begin
                grant_d = 1'b1;
            end else if (if_req) begin
                grant_i = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_d) begin
                    state_d = StBusyD;
                end else if (grant_i) begin
                    state_d = StBusyI;
                end
            end
            StBusyI, StBusyD: begin
                if (lat_zero) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: acks fire in the final cycle of the access
    always_comb begin
        if_ack = (state_q == StBusyI) && lat_zero;
        dm_ack = (state_q == StBusyD) && lat_zero;
    end

    access_timer u_access_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (grant_i | grant_d),
        .load_val (LatLoad),
        .zero     (lat_zero)
    );

    // Starvation counter: counts data grants that bypassed a waiting fetch.
    always_comb begin
        starve_d = starve_q;
        if (grant_i) begin
            starve_d = '0;
        end else if (grant_d) begin
            if (!if_req) begin
                starve_d = '0;
            end else if (starve_q >= StarveMax) begin
                starve_d = StarveMax;
            end else begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    // Memory port registers: loaded on grant, held while busy, enable dropped
    // after the ack cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else if (grant_d) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_we;
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
        end else if (grant_i) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
        end else if (if_ack || dm_ack) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

endmodule
